stream_demux12: RTL and testbench
=================================

// Module: stream_demux12
// PURPOSE
//  1-to-2 packet stream demultiplexer; receive-side counterpart of the 2:1 channel mux.
//  Routes a valid/ready input stream to out0 or out1 by in_sel, locking the route per packet.
//  Each output has a 2-entry buffer, so there is no combinational path from out*_ready to in_ready.
//  Sits between a shared link and two per-channel consumers.
// PARAMETERS
//  WIDTH   8   data width of in_data / out*_data
//  CNT_W   16  width of per-output delivered-beat counters
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  reset       in   1      synchronous, active-high
//  in_valid    in   1      input beat valid
//  in_ready    out  1      input beat accepted when in_valid & in_ready
//  in_sel      in   1      destination: 0 -> out0, 1 -> out1 (sampled on first beat of packet)
//  in_last     in   1      last beat of packet
//  in_data     in   WIDTH  payload
//  out0_valid  out  1      / out1_valid: output beat valid
//  out0_ready  in   1      / out1_ready: consumer ready
//  out0_last   out  1      / out1_last: last flag of head beat
//  out0_data   out  WIDTH  / out1_data: head beat payload
//  beats0      out  CNT_W  / beats1: beats delivered on out0/out1 (out handshake), wraps at 2^CNT_W
//  err_sel     out  1      sticky: in_sel changed mid-packet
// BEHAVIOUR
//  - Reset (sync, high): state IDLE, both buffers empty, out*_valid=0, out*_data/last=0,
//    beats*=0, err_sel=0. After reset, in_ready=1. Reset mid-packet flushes buffers and drops lock.
//  - route = (state==IDLE) ? in_sel : locked_sel.
//  - in_ready = (count[route] < 2). count is registered; no dependence on out*_ready.
//  - FSM: IDLE --accept & !in_last--> BUSY (locked_sel <= in_sel).
//    BUSY --accept & in_last--> IDLE. Single-beat packet (last on first beat) stays IDLE.
//    No other transitions.
//  - Accepted beat {in_last,in_data} is pushed into buffer[route] at the clock edge.
//    It appears on out<route>_valid the next cycle if that buffer was empty: latency 1.
//  - Buffer: 2-entry FIFO. out_valid = (count!=0); data/last = head entry.
//    Pop on out_valid & out_ready. Push and pop in the same cycle keep count unchanged,
//    order preserved. Push is never attempted when count==2; in_ready guarantees this.
//  - Buffers drain independently: a full out1 does not stall a packet routed to out0.
//  - err_sel: set when state==BUSY & in_valid & (in_sel != locked_sel), whether or not the
//    beat is accepted. Cleared only by reset. The beat still goes to locked_sel.
//  - beats*: +1 per output handshake, modulo 2^CNT_W.
//  - All outputs are driven from registers except in_ready, which decodes registered counts
//    and in_sel in IDLE.
// STRUCTURE
//  - Package stream_demux_pkg: typedef enum logic {IDLE, BUSY} state_t; localparams PORT0=0, PORT1=1.
//  - Sub-module skid_fifo2 #(W): 2-entry FIFO with push/pop/count/full/empty.
//    Instanced twice with W=WIDTH+1.
//  - Top level: FSM, route/lock register, err_sel, counters.
// TESTING
//  1. Reset then in_sel=0, 1-beat pkt data=0xA5 last=1
//     -> next cycle out0_valid=1, out0_data=0xA5, out0_last=1; out1_valid=0; beats0=1 after handshake.
//  2. 4-beat pkt, in_sel=1 on beat0 then toggled to 0 on beats 1-3
//     -> all 4 beats on out1 in order; err_sel=1 and stays 1 until reset.
//  3. out0_ready=0, stream 3 beats to out0
//     -> beats 1-2 accepted, in_ready=0 on third; raise out0_ready -> third accepted the next cycle, order kept.
//  4. out0 full & stalled, new pkt in_sel=1 -> in_ready=1, beats reach out1 with latency 1.
//  5. Continuous push and pop on out1 at full rate -> count steady, one beat/cycle throughput, no bubbles.
//  6. Assert reset mid-packet with both buffers holding data
//     -> next cycle out*_valid=0, beats*=0, state IDLE; next beat routed by its in_sel.

Source files
------------

// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_pkg
//  Description : Shared types and constants for the 1-to-2 packet stream
//                demultiplexer (FSM state encoding, output port indices).
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

endpackage
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : skid_fifo2
//  Description : Two-entry FIFO built from a head and a tail register. The
//                head register always holds the oldest entry, so the read
//                data comes straight from a flop with no output mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head_data,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_do_pop;

    // A pop on an empty FIFO is ignored.
    assign w_do_pop = i_pop && (r_count != 2'd0);

    // Head/tail shift register with occupancy count; push+pop keeps count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= i_push_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && w_do_pop) begin
                        r_head <= i_push_data;
                    end else if (i_push) begin
                        r_tail  <= i_push_data;
                        r_count <= 2'd2;
                    end else if (w_do_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (w_do_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_push_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head_data = r_head;
    assign o_count     = r_count;
    assign o_full      = (r_count == 2'd2);
    assign o_empty     = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/stream_demux12.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux12
//  Description : 1-to-2 packet stream demultiplexer. The destination is taken
//                from in_sel on the first beat of a packet and held until the
//                last beat. Each output owns a 2-entry buffer so in_ready only
//                depends on registered occupancy, never on out*_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux12
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic             out0_last,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             out1_last,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] beats0,
    output logic [CNT_W-1:0] beats1,
    output logic             err_sel
);

    localparam logic [0:0] c_ST_IDLE = IDLE;
    localparam logic [0:0] c_ST_BUSY = BUSY;

    logic [0:0]       r_state;
    logic             r_locked_sel;
    logic             r_err_sel;
    logic [CNT_W-1:0] r_beats [2];

    logic             w_route;
    logic             w_accept;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [1:0]       w_out_ready;
    logic [1:0]       w_count [2];
    logic [WIDTH:0]   w_head  [2];

    // Route is live in_sel between packets, locked selection inside one.
    assign w_route     = (r_state == c_ST_IDLE) ? in_sel : r_locked_sel;
    assign in_ready    = (w_count[w_route] < 2'd2);
    assign w_accept    = in_valid && in_ready;
    assign w_out_ready = {out1_ready, out0_ready};

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            // full is already excluded by in_ready; the extra term keeps a
            // stray push from ever corrupting a full buffer.
            assign w_push[p] = w_accept && (w_route == p[0]) && !w_full[p];
            assign w_pop[p]  = !w_empty[p] && w_out_ready[p];

            skid_fifo2 #(
                .W (WIDTH + 1)
            ) u_fifo (
                .clk         (clk),
                .reset       (reset),
                .i_push      (w_push[p]),
                .i_push_data ({in_last, in_data}),
                .i_pop       (w_pop[p]),
                .o_head_data (w_head[p]),
                .o_count     (w_count[p]),
                .o_full      (w_full[p]),
                .o_empty     (w_empty[p])
            );
        end
    endgenerate

    // Packet framing FSM: lock the route on a non-final first beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_locked_sel <= 1'b0;
        end else if (w_accept) begin
            if (r_state == c_ST_IDLE && !in_last) begin
                r_state      <= c_ST_BUSY;
                r_locked_sel <= in_sel;
            end else if (r_state == c_ST_BUSY && in_last) begin
                r_state <= c_ST_IDLE;
            end
        end
    end

    // Sticky flag for in_sel wandering away from the locked route mid-packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_sel <= 1'b0;
        end else if (r_state == c_ST_BUSY && in_valid && (in_sel != r_locked_sel)) begin
            r_err_sel <= 1'b1;
        end
    end

    // Per-output delivered-beat counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beats[PORT0] <= '0;
            r_beats[PORT1] <= '0;
        end else begin
            if (w_pop[PORT0]) r_beats[PORT0] <= r_beats[PORT0] + 1'b1;
            if (w_pop[PORT1]) r_beats[PORT1] <= r_beats[PORT1] + 1'b1;
        end
    end

    assign out0_valid = !w_empty[PORT0];
    assign out0_last  = w_head[PORT0][WIDTH];
    assign out0_data  = w_head[PORT0][WIDTH-1:0];
    assign out1_valid = !w_empty[PORT1];
    assign out1_last  = w_head[PORT1][WIDTH];
    assign out1_data  = w_head[PORT1][WIDTH-1:0];
    assign beats0     = r_beats[PORT0];
    assign beats1     = r_beats[PORT1];
    assign err_sel    = r_err_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux12.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_demux12
//  Description : Self-checking bench for stream_demux12. A reference model
//                predicts in_ready, output occupancy, counters and err_sel,
//                and queues expected beats per output for in-order compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sel = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out0_valid, out1_valid;
    logic        out0_ready = 1'b1;
    logic        out1_ready = 1'b1;
    logic        out0_last, out1_last;
    logic [7:0]  out0_data, out1_data;
    logic [15:0] beats0, beats1;
    logic        err_sel;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];
    int          m_cnt [2];
    logic [15:0] m_beats [2];
    logic        m_busy = 1'b0;
    logic        m_lock = 1'b0;
    logic        m_err  = 1'b0;

    stream_demux12 #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_last  (out0_last),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_last  (out1_last),
        .out1_data  (out1_data),
        .beats0     (beats0),
        .beats1     (beats1),
        .err_sel    (err_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Model step: checks at the falling edge, then advances to the next rising edge.
    always @(negedge clk) begin
        logic       r;
        logic       rdy;
        logic [1:0] pop;
        logic [1:0] push;
        logic [8:0] e;
        if (mon_en) begin
            r   = m_busy ? m_lock : in_sel;
            rdy = (m_cnt[r] < 2);
            chk("in_ready",   32'(in_ready),   32'(rdy));
            chk("out0_valid", 32'(out0_valid), 32'(m_cnt[0] != 0));
            chk("out1_valid", 32'(out1_valid), 32'(m_cnt[1] != 0));
            chk("beats0",     32'(beats0),     32'(m_beats[0]));
            chk("beats1",     32'(beats1),     32'(m_beats[1]));
            chk("err_sel",    32'(err_sel),    32'(m_err));
            pop = 2'b00;
            if (out0_valid && out0_ready) begin
                pop[0] = 1'b1;
                if (q0.size() == 0) chk("q0_underflow", 32'(1), 32'(0));
                else begin
                    e = q0.pop_front();
                    chk("out0_beat", 32'({out0_last, out0_data}), 32'(e));
                end
            end
            if (out1_valid && out1_ready) begin
                pop[1] = 1'b1;
                if (q1.size() == 0) chk("q1_underflow", 32'(1), 32'(0));
                else begin
                    e = q1.pop_front();
                    chk("out1_beat", 32'({out1_last, out1_data}), 32'(e));
                end
            end
            if (reset) begin
                q0.delete();
                q1.delete();
                m_cnt[0] = 0;     m_cnt[1] = 0;
                m_beats[0] = '0;  m_beats[1] = '0;
                m_busy = 1'b0;    m_lock = 1'b0;    m_err = 1'b0;
            end else begin
                push = 2'b00;
                if (in_valid && rdy) begin
                    push[r] = 1'b1;
                    if (r) q1.push_back({in_last, in_data});
                    else   q0.push_back({in_last, in_data});
                end
                if (m_busy && in_valid && (in_sel != m_lock)) m_err = 1'b1;
                if (in_valid && rdy) begin
                    if (!m_busy && !in_last) begin
                        m_busy = 1'b1;
                        m_lock = in_sel;
                    end else if (m_busy && in_last) begin
                        m_busy = 1'b0;
                    end
                end
                m_cnt[0] = m_cnt[0] + int'(push[0]) - int'(pop[0]);
                m_cnt[1] = m_cnt[1] + int'(push[1]) - int'(pop[1]);
                m_beats[0] = m_beats[0] + 16'(pop[0]);
                m_beats[1] = m_beats[1] + 16'(pop[1]);
            end
        end
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic s, input logic l, input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_sel   = s;
        in_last  = l;
        in_data  = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        m_cnt[0] = 0;    m_cnt[1] = 0;
        m_beats[0] = '0; m_beats[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready),   32'(1));
        chk("rst_out0_val", 32'(out0_valid), 32'(0));
        chk("rst_out1_val", 32'(out1_valid), 32'(0));
        chk("rst_out0_dat", 32'(out0_data),  32'(0));
        chk("rst_beats0",   32'(beats0),     32'(0));
        chk("rst_err",      32'(err_sel),    32'(0));
        @(posedge clk);
        #1;

        // 1: single-beat packet to out0, latency 1
        send(1'b0, 1'b1, 8'hA5);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_out0_valid", 32'(out0_valid), 32'(1));
        chk("t1_out0_data",  32'(out0_data),  32'(8'hA5));
        chk("t1_out0_last",  32'(out0_last),  32'(1));
        chk("t1_out1_valid", 32'(out1_valid), 32'(0));
        idle(2);
        chk("t1_beats0", 32'(beats0), 32'(1));

        // 2: in_sel toggles mid-packet; beats stay on out1
        send(1'b1, 1'b0, 8'h10);
        send(1'b0, 1'b0, 8'h11);
        send(1'b0, 1'b0, 8'h12);
        send(1'b0, 1'b1, 8'h13);
        idle(4);
        chk("t2_err_sel", 32'(err_sel), 32'(1));
        chk("t2_beats1",  32'(beats1),  32'(4));
        chk("t2_beats0",  32'(beats0),  32'(1));

        // 3: stalled out0 fills after two beats, third waits for space
        out0_ready = 1'b0;
        send(1'b0, 1'b0, 8'h20);
        send(1'b0, 1'b0, 8'h21);
        in_valid = 1'b1; in_sel = 1'b0; in_last = 1'b1; in_data = 8'h22;
        @(negedge clk);
        chk("t3_stall", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        out0_ready = 1'b1;
        send(1'b0, 1'b1, 8'h22);
        idle(4);

        // 4: out0 full and stalled does not block out1
        out0_ready = 1'b0;
        send(1'b0, 1'b0, 8'h30);
        send(1'b0, 1'b1, 8'h31);
        in_valid = 1'b1; in_sel = 1'b1; in_last = 1'b0; in_data = 8'h40;
        @(negedge clk);
        chk("t4_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_out1_valid", 32'(out1_valid), 32'(1));
        chk("t4_out1_data",  32'(out1_data),  32'(8'h40));
        @(posedge clk);
        #1;
        send(1'b1, 1'b1, 8'h41);
        out0_ready = 1'b1;
        idle(4);

        // 5: full-rate streaming on out1
        c0 = cyc;
        for (int i = 0; i < 20; i++) send(1'b1, (i == 19), 8'(8'h60 + i));
        chk("t5_cycles", 32'(cyc - c0), 32'(20));
        idle(4);

        // 6: reset mid-packet with both buffers loaded
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 1'b1, 8'h50);
        send(1'b1, 1'b1, 8'h51);
        send(1'b0, 1'b0, 8'h52);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_out0_valid", 32'(out0_valid), 32'(0));
        chk("t6_out1_valid", 32'(out1_valid), 32'(0));
        chk("t6_beats0",     32'(beats0),     32'(0));
        chk("t6_beats1",     32'(beats1),     32'(0));
        chk("t6_err",        32'(err_sel),    32'(0));
        @(posedge clk);
        #1;
        out1_ready = 1'b1;
        send(1'b1, 1'b1, 8'h70);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_route_out1", 32'(out1_valid), 32'(1));
        chk("t6_data_out1",  32'(out1_data),  32'(8'h70));
        chk("t6_out0_idle",  32'(out0_valid), 32'(0));
        @(posedge clk);
        #1;

        out0_ready = 1'b1;
        idle(5);
        chk("drain_q0", 32'(q0.size()), 32'(0));
        chk("drain_q1", 32'(q1.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
